prefetch: RTL
=============

// Module: prefetch
// PURPOSE
//  Instruction prefetcher feeding the byte-wide instruction FIFO that the
//  immediate reader and decoder pop. Fetches 16-bit words from the memory
//  bus at CS:IP, pushes one byte per cycle into the FIFO, and flushes and
//  restarts on a branch (new CS:IP load).
// PARAMETERS
//  RESET_CS  16'hFFFF  code segment after reset
//  RESET_IP  16'h0000  fetch IP after reset
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-high reset
//  load_new_ip    in   1   branch: replace CS:IP, flush FIFO
//  new_cs         in   16  segment loaded with load_new_ip
//  new_ip         in   16  offset loaded with load_new_ip
//  fifo_full      in   1   FIFO cannot accept a byte this cycle
//  fifo_wr_en     out  1   push fifo_wr_data this cycle
//  fifo_wr_data   out  8   byte pushed
//  fifo_reset     out  1   one-cycle FIFO flush pulse
//  mem_access     out  1   bus read request, held until mem_ack
//  mem_ack        in   1   bus read complete, mem_data valid
//  mem_address    out  19  word address, phys[19:1]
//  mem_data       in   16  read data; [7:0] even byte, [15:8] odd byte
// BEHAVIOUR
//  - Reset: mem_access=0, fifo_wr_en=0, fifo_reset=0, cs=RESET_CS,
//    ip=RESET_IP, byte buffer empty, state IDLE.
//  - phys = {cs,4'b0} + {4'b0,ip}, mod 2^20. mem_address = phys[19:1],
//    combinational from cs/ip. Reset value: 19'h7FFF8.
//  - States:
//    IDLE: buffer empty and !fifo_full -> FETCH. mem_access rises the next cycle.
//    FETCH: mem_access=1 until the mem_ack cycle, inclusive.
//      On ack, capture the word. Even ip: 2 bytes valid, ip+=2.
//      Odd ip: only [15:8] valid, ip+=1. Go to DRAIN.
//    DRAIN: fifo_wr_en = !fifo_full. Low byte first, then high.
//      Earliest first push is the cycle after ack.
//      Buffer empty -> IDLE, then FETCH the next cycle if room.
//    ABORT: branch arrived while a request was in flight.
//      Keep mem_access=1 until mem_ack, discard the data, then go to IDLE.
//  - ip arithmetic is 16 bits and wraps inside the segment; cs never
//    increments. Example: ip=FFFF fetches 1 byte, next ip=0000.
//  - load_new_ip, any state: cs<=new_cs, ip<=new_ip, buffer cleared.
//    fifo_reset=1 the next cycle only. fifo_wr_en=0 in the load cycle
//    and in the fifo_reset cycle. Next state: ABORT if FETCH without ack
//    this cycle, else IDLE.
//  - load_new_ip in the same cycle as mem_ack: the data is dropped and
//    the state goes to IDLE. A branch wins over any push or capture.
//  - fifo_full held: no push and no new fetch. The buffer holds its bytes
//    indefinitely, with no loss or duplication.
//  - The bus is never read without room for at least one byte; mem_access
//    never drops before mem_ack.
// CONFIGURATION
//  PREFETCH_PERF_EN defined:
//    - Adds output perf_stall_cycles[15:0], reset 0.
//    - Increments each cycle that DRAIN has a byte pending and fifo_full=1.
//    - Saturates at 16'hFFFF; cleared by load_new_ip.
//  PREFETCH_PERF_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. Release reset, mem returns 16'hAA55 at ack, FIFO never full.
//     -> mem_address=19'h7FFF8; pushes 55, then AA on consecutive cycles;
//        next fetch at 19'h7FFF9.
//  2. new_cs=0000, new_ip=0003, mem_data=16'h1234
//     -> fifo_reset pulse; single push 12; next mem_address=19'h00002.
//  3. Branch while FETCH waits 3 cycles for ack
//     -> mem_access held to ack; data not pushed; refetch at new address.
//  4. fifo_full=1 for 5 cycles with 2 bytes buffered
//     -> no pushes or requests; both bytes pushed in order after release;
//        perf_stall_cycles=5 (with PREFETCH_PERF_EN).
//  5. cs=F000, ip=FFFF -> 1 byte pushed, then ip wraps to 0000
//     -> next mem_address=19'h78000.
//  6. Assert reset during DRAIN -> outputs zero immediately; after release,
//     fetch restarts at the reset vector.

Source files
------------

// File: rtl/prefetch.sv
// Instruction prefetcher: reads 16-bit words at CS:IP and pushes them one byte per cycle into the instruction FIFO.
// Optional stall counter output perf_stall_cycles is built in when PREFETCH_PERF_EN is defined.
module prefetch #(
  parameter logic [15:0] RESET_CS = 16'hFFFF,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_new_ip,
  input  logic [15:0] new_cs,
  input  logic [15:0] new_ip,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_wr_data,
  output logic        fifo_reset,
  output logic        mem_access,
  input  logic        mem_ack,
  output logic [18:0] mem_address,
  input  logic [15:0] mem_data
`ifdef PREFETCH_PERF_EN
  ,
  output logic [15:0] perf_stall_cycles
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [1:0]  state;
  logic [15:0] cs;
  logic [15:0] ip;
  logic [7:0]  buf_lo;
  logic [7:0]  buf_hi;
  logic [1:0]  buf_cnt;
  logic [19:0] phys;
  logic        byte_pending;

  assign phys         = {cs, 4'b0000} + {4'b0000, ip};
  assign mem_address  = phys[19:1];
  // Both FETCH and ABORT keep the request up so the bus never sees it withdrawn before ack.
  assign mem_access   = (state == FETCH) || (state == ABORT);
  assign byte_pending = (state == DRAIN) && (buf_cnt != 2'd0);
  assign fifo_wr_en   = byte_pending && !fifo_full && !load_new_ip && !fifo_reset;
  assign fifo_wr_data = buf_lo;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cs         <= RESET_CS;
      ip         <= RESET_IP;
      buf_lo     <= 8'h00;
      buf_hi     <= 8'h00;
      buf_cnt    <= 2'd0;
      fifo_reset <= 1'b0;
    end else begin
      fifo_reset <= load_new_ip;
      if (load_new_ip) begin
        // A branch outranks capture and push; an unacked request must still be seen through.
        cs      <= new_cs;
        ip      <= new_ip;
        buf_cnt <= 2'd0;
        state   <= (mem_access && !mem_ack) ? ABORT : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (!fifo_full) state <= FETCH;
          end
          FETCH: begin
            if (mem_ack) begin
              if (ip[0]) begin
                buf_lo  <= mem_data[15:8];
                buf_cnt <= 2'd1;
                ip      <= ip + 16'd1;
              end else begin
                buf_lo  <= mem_data[7:0];
                buf_hi  <= mem_data[15:8];
                buf_cnt <= 2'd2;
                ip      <= ip + 16'd2;
              end
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (buf_cnt == 2'd0) begin
              state <= IDLE;
            end else if (fifo_wr_en) begin
              buf_lo  <= buf_hi;
              buf_cnt <= buf_cnt - 2'd1;
              if (buf_cnt == 2'd1) state <= IDLE;
            end
          end
          ABORT: begin
            if (mem_ack) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef PREFETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= 16'h0000;
    end else if (load_new_ip) begin
      perf_stall_cycles <= 16'h0000;
    end else if (byte_pending && fifo_full && (perf_stall_cycles != 16'hFFFF)) begin
      perf_stall_cycles <= perf_stall_cycles + 16'd1;
    end
  end
`endif

endmodule
